// File: rtl/mux8x1_rr_select.sv
// mux8x1_rr_select: round-robin sequencer that drives the 3-bit select of an
// 8:1 4-bit mux. Each grant is held until acked, followed by an optional dead time.
module mux8x1_rr_select #(
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        req,
  input  logic              ack,
  input  logic [HOLD_W-1:0] hold_len,
  output logic [2:0]        sl,
  output logic              vld,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        ptr;
  logic [HOLD_W-1:0] cnt;

  logic [2:0]        next_idx;
  logic [2:0]        cand;
  logic              found;

  // Rotating priority search: first requesting index at or after ptr, wrapping mod 8.
  always_comb begin
    next_idx = ptr;
    cand     = ptr;
    found    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && req[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

  // Busy whenever a grant is live or the dead time is running.
  assign busy = (state != IDLE);

  // Arbitration state machine with registered select and valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      cnt   <= '0;
      sl    <= 3'd0;
      vld   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sl    <= next_idx;
            vld   <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          // A withdrawn request releases the grant without advancing ptr,
          // and takes priority over an ack in the same cycle.
          if (!req[sl]) begin
            vld   <= 1'b0;
            state <= IDLE;
          end else if (ack) begin
            ptr <= sl + 3'd1;
            vld <= 1'b0;
            if (hold_len == '0) begin
              state <= IDLE;
            end else begin
              cnt   <= hold_len;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          cnt <= cnt - 1'b1;
          vld <= 1'b0;
          if (cnt == HOLD_W'(1)) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          vld   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8x1_rr_select.sv
// tb_mux8x1_rr_select: directed stimulus for the round-robin select sequencer,
// checked every cycle against a behavioural model plus hand-computed literals.
module tb_mux8x1_rr_select;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       ack;
  logic [3:0] hold_len;
  logic [2:0] sl;
  logic       vld;
  logic       busy;

  int checks;
  int failures;
  bit check_en;

  // Behavioural model: live grant flag, granted index, rotation start, dead cycles left.
  bit m_vld;
  int m_sl;
  int m_ptr;
  int m_dead;

  mux8x1_rr_select #(.HOLD_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ack      (ack),
    .hold_len (hold_len),
    .sl       (sl),
    .vld      (vld),
    .busy     (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model reset follows the asynchronous reset immediately.
  always @(negedge rst_n) begin
    m_vld  = 1'b0;
    m_sl   = 0;
    m_ptr  = 0;
    m_dead = 0;
  end

  // Model advance on each rising edge from the rules of the sequencer.
  always @(posedge clk) begin
    if (rst_n) begin
      if (m_dead > 0) begin
        m_dead = m_dead - 1;
      end else if (m_vld) begin
        if (!req[m_sl]) begin
          m_vld = 1'b0;
        end else if (ack) begin
          m_vld  = 1'b0;
          m_ptr  = (m_sl + 1) % 8;
          m_dead = int'(hold_len);
        end
      end else if (req != 8'h00) begin
        for (int d = 0; d < 8; d++) begin
          if (!m_vld && req[(m_ptr + d) % 8]) begin
            m_sl  = (m_ptr + d) % 8;
            m_vld = 1'b1;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      checks++;
      if (sl !== 3'(m_sl) || vld !== m_vld || busy !== (m_vld || m_dead > 0)) begin
        failures++;
        $display("[TB] FAIL model_cmp t=%0t got sl=%0d vld=%0b busy=%0b expected sl=%0d vld=%0b busy=%0b",
                 $time, sl, vld, busy, m_sl, m_vld, (m_vld || m_dead > 0));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] r, input logic a, input logic [3:0] h, input int n);
    req      = r;
    ack      = a;
    hold_len = h;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic checkOutput(input string name, input logic [2:0] e_sl, input logic e_vld, input logic e_busy);
    checks++;
    if (sl !== e_sl || vld !== e_vld || busy !== e_busy) begin
      failures++;
      $display("[TB] FAIL %s got sl=%0d vld=%0b busy=%0b expected sl=%0d vld=%0b busy=%0b",
               name, sl, vld, busy, e_sl, e_vld, e_busy);
    end
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    req   = 8'h00;
    ack   = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    check_en = 1'b0;
    rst_n    = 1'b1;
    req      = 8'h00;
    ack      = 1'b0;
    hold_len = 4'd0;
    #1;
    rst_n    = 1'b0;
    #1;
    check_en = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    checkOutput("reset_state", 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Single requester, ack held high
    applyStimulus(8'h10, 1'b1, 4'd0, 1);
    checkOutput("single_grant", 3'd4, 1'b1, 1'b1);
    applyStimulus(8'h10, 1'b1, 4'd0, 1);
    checkOutput("single_release", 3'd4, 1'b0, 1'b0);
    applyStimulus(8'h21, 1'b0, 4'd0, 1);
    checkOutput("ptr_after_single", 3'd5, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 4'd0, 1);
    checkOutput("withdraw_idle", 3'd5, 1'b0, 1'b0);

    // Full rotation with zero dead time
    pulseReset();
    for (int g = 0; g < 9; g++) begin
      applyStimulus(8'hFF, 1'b1, 4'd0, 1);
      checkOutput("rr_grant", 3'(g % 8), 1'b1, 1'b1);
      applyStimulus(8'hFF, 1'b1, 4'd0, 1);
      checkOutput("rr_gap", 3'(g % 8), 1'b0, 1'b0);
    end
    applyStimulus(8'h00, 1'b0, 4'd0, 1);

    // Pointer skip and wrap after a grant of 6
    applyStimulus(8'h40, 1'b1, 4'd0, 1);
    checkOutput("grant6", 3'd6, 1'b1, 1'b1);
    applyStimulus(8'h40, 1'b1, 4'd0, 1);
    applyStimulus(8'h05, 1'b1, 4'd0, 1);
    checkOutput("wrap_to0", 3'd0, 1'b1, 1'b1);
    applyStimulus(8'h05, 1'b1, 4'd0, 1);
    checkOutput("wrap_rel0", 3'd0, 1'b0, 1'b0);
    applyStimulus(8'h05, 1'b1, 4'd0, 1);
    checkOutput("skip_to2", 3'd2, 1'b1, 1'b1);
    applyStimulus(8'h05, 1'b1, 4'd0, 1);
    applyStimulus(8'h00, 1'b0, 4'd0, 1);

    // Dead time of three cycles
    applyStimulus(8'h03, 1'b0, 4'd3, 1);
    checkOutput("dead_grant0", 3'd0, 1'b1, 1'b1);
    applyStimulus(8'h03, 1'b1, 4'd3, 1);
    checkOutput("dead_hold3", 3'd0, 1'b0, 1'b1);
    applyStimulus(8'h03, 1'b0, 4'd3, 1);
    checkOutput("dead_hold2", 3'd0, 1'b0, 1'b1);
    applyStimulus(8'h03, 1'b0, 4'd3, 1);
    checkOutput("dead_hold1", 3'd0, 1'b0, 1'b1);
    applyStimulus(8'h03, 1'b0, 4'd3, 1);
    checkOutput("dead_idle", 3'd0, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b0, 4'd3, 1);
    checkOutput("dead_grant1", 3'd1, 1'b1, 1'b1);

    // Asynchronous reset while in HOLD with two cycles left
    applyStimulus(8'h03, 1'b1, 4'd2, 1);
    checkOutput("hold_before_rst", 3'd1, 1'b0, 1'b1);
    ack   = 1'b0;
    req   = 8'h00;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 3'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'h82, 1'b0, 4'd0, 1);
    checkOutput("post_rst_grant", 3'd1, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 4'd0, 1);

    // Withdrawal beats ack and does not advance the pointer
    applyStimulus(8'h0C, 1'b0, 4'd0, 1);
    checkOutput("wd_grant2", 3'd2, 1'b1, 1'b1);
    applyStimulus(8'h08, 1'b1, 4'd0, 1);
    checkOutput("wd_release", 3'd2, 1'b0, 1'b0);
    applyStimulus(8'h08, 1'b0, 4'd0, 1);
    checkOutput("wd_grant3", 3'd3, 1'b1, 1'b1);
    applyStimulus(8'h14, 1'b0, 4'd0, 1);
    checkOutput("wd_release3", 3'd3, 1'b0, 1'b0);
    applyStimulus(8'h14, 1'b0, 4'd0, 1);
    checkOutput("wd_no_credit", 3'd2, 1'b1, 1'b1);
    applyStimulus(8'h14, 1'b1, 4'd0, 1);
    applyStimulus(8'h00, 1'b1, 4'd0, 2);
    checkOutput("ack_ignored", 3'd2, 1'b0, 1'b0);
    applyStimulus(8'h14, 1'b1, 4'd0, 1);
    checkOutput("grant4", 3'd4, 1'b1, 1'b1);
    applyStimulus(8'h00, 1'b0, 4'd0, 2);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
